pla_seq_engine: RTL and testbench



---
 rtl/pla_seq_engine_pkg.sv | 25 ++
 rtl/pla_seq_engine_if.sv | 38 +++
 rtl/pla_seq_engine_term_match.sv | 29 ++
 rtl/pla_seq_engine.sv | 165 ++++++++++++++++
 tb/tb_pla_seq_engine.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pla_seq_engine_pkg.sv
// Shared cube codes, FSM state type and sizing helpers for the sequential PLA engine.
package pla_seq_pkg;

    localparam logic [1:0] CUBE_ONE  = 2'b10;
    localparam logic [1:0] CUBE_ZERO = 2'b01;
    localparam logic [1:0] CUBE_DC   = 2'b11;
    localparam logic [1:0] CUBE_NULL = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // Number of LANES-wide groups needed to sweep the whole term plane.
    function automatic int calc_groups(input int n_terms, input int lanes);
        return (n_terms + lanes - 1) / lanes;
    endfunction

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pla_seq_engine_if.sv
// Programming port plus input/output valid-ready channels of the PLA engine.
interface pla_seq_engine_if #(
    parameter int N_IN    = 10,
    parameter int N_OUT   = 12,
    parameter int N_TERMS = 32
);
    import pla_seq_pkg::*;

    localparam int AW = index_width(N_TERMS);
    localparam int HW = $clog2(N_TERMS + 1);

    logic                prog_we;
    logic [AW-1:0]       prog_addr;
    logic [2*N_IN-1:0]   prog_and;
    logic [N_OUT-1:0]    prog_or;

    logic                in_valid;
    logic                in_ready;
    logic [N_IN-1:0]     in_x;

    logic                out_valid;
    logic                out_ready;
    logic [N_OUT-1:0]    out_z;
    logic [HW-1:0]       out_hits;

    modport master (
        output prog_we, prog_addr, prog_and, prog_or,
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_z, out_hits
    );

    modport slave (
        input  prog_we, prog_addr, prog_and, prog_or,
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_z, out_hits
    );

endinterface

// File: rtl/pla_seq_engine_term_match.sv
// Combinational match of one two-bit-per-input cube against an input vector.
module pla_term_match
    import pla_seq_pkg::*;
#(
    parameter int N_IN = 10
) (
    input  logic [2*N_IN-1:0] cube,
    input  logic [N_IN-1:0]   x,
    output logic              match
);

    logic [N_IN-1:0] pos_ok;

    always_comb begin
        pos_ok = '0;
        for (int i = 0; i < N_IN; i++) begin
            case (cube[2*i +: 2])
                CUBE_ONE:  pos_ok[i] = x[i];
                CUBE_ZERO: pos_ok[i] = ~x[i];
                CUBE_DC:   pos_ok[i] = 1'b1;
                CUBE_NULL: pos_ok[i] = 1'b0;
                default:   pos_ok[i] = 1'b0;
            endcase
        end
    end

    assign match = &pos_ok;

endmodule

// File: rtl/pla_seq_engine.sv
// Programmable PLA held in flops; sweeps LANES product terms per cycle for one
// latched input vector at a time.
module pla_seq_engine
    import pla_seq_pkg::*;
#(
    parameter int N_IN    = 10,
    parameter int N_OUT   = 12,
    parameter int N_TERMS = 32,
    parameter int LANES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    pla_seq_engine_if.slave  bus
);

    localparam int G  = calc_groups(N_TERMS, LANES);
    localparam int AW = index_width(N_TERMS);
    localparam int GW = index_width(G);
    localparam int HW = $clog2(N_TERMS + 1);

    state_t             state_q;
    state_t             state_d;

    logic [2*N_IN-1:0]  cube_q [N_TERMS];
    logic [N_OUT-1:0]   row_q  [N_TERMS];

    logic [N_IN-1:0]    x_q;
    logic [GW-1:0]      g_q;
    logic [N_OUT-1:0]   acc_z;
    logic [HW-1:0]      acc_hits;

    logic               addr_ok;
    logic               accept;
    logic               last_group;

    logic [2*N_IN-1:0]  lane_cube [LANES];
    logic [N_OUT-1:0]   lane_row  [LANES];
    logic [LANES-1:0]   lane_match;
    logic [N_OUT-1:0]   group_z;
    logic [HW-1:0]      group_hits;
    logic [HW:0]        hits_sum;
    logic [HW-1:0]      hits_next;

    // Only a non-power-of-two plane can see addresses past its end.
    generate
        if ((1 << AW) > N_TERMS) begin : g_addr_chk
            assign addr_ok = (bus.prog_addr < AW'(N_TERMS));
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_group = (g_q == GW'(G - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_z     = '0;
        bus.out_hits  = '0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (last_group) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_z     = acc_z;
                bus.out_hits  = acc_hits;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes share the accept edge, so a vector accepted alongside a write
    // is evaluated against the freshly written term.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TERMS; t++) begin
                cube_q[t] <= '0;
                row_q[t]  <= '0;
            end
        end else if ((state_q == IDLE) && bus.prog_we && addr_ok) begin
            cube_q[bus.prog_addr] <= bus.prog_and;
            row_q[bus.prog_addr]  <= bus.prog_or;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_cube[l] = '0;
            lane_row[l]  = '0;
            if (int'(g_q) * LANES + l < N_TERMS) begin
                lane_cube[l] = cube_q[AW'(int'(g_q) * LANES + l)];
                lane_row[l]  = row_q[AW'(int'(g_q) * LANES + l)];
            end
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pla_term_match #(
                .N_IN (N_IN)
            ) u_match (
                .cube  (lane_cube[l]),
                .x     (x_q),
                .match (lane_match[l])
            );
        end
    endgenerate

    always_comb begin
        group_z    = '0;
        group_hits = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_match[l]) begin
                group_z    = group_z | lane_row[l];
                group_hits = group_hits + HW'(1);
            end
        end
    end

    assign hits_sum  = {1'b0, acc_hits} + {1'b0, group_hits};
    assign hits_next = (hits_sum > (HW+1)'(N_TERMS)) ? HW'(N_TERMS) : hits_sum[HW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            g_q      <= '0;
            acc_z    <= '0;
            acc_hits <= '0;
        end else if (accept) begin
            x_q      <= bus.in_x;
            g_q      <= '0;
            acc_z    <= '0;
            acc_hits <= '0;
        end else if (state_q == EVAL) begin
            acc_z    <= acc_z | group_z;
            acc_hits <= hits_next;
            if (!last_group) begin
                g_q <= g_q + GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pla_seq_engine.sv
// Directed plus randomized bench for pla_seq_engine, checked against a flat
// term-by-term reference model of the PLA.
module tb_pla_seq_engine;
    import pla_seq_pkg::*;

    localparam int N_IN    = 10;
    localparam int N_OUT   = 12;
    localparam int N_TERMS = 32;
    localparam int LANES   = 4;
    localparam int G       = (N_TERMS + LANES - 1) / LANES;
    localparam int AW      = $clog2(N_TERMS);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [2*N_IN-1:0] m_cube [N_TERMS];
    logic [N_OUT-1:0]  m_row  [N_TERMS];

    logic [N_OUT-1:0]  last_z;
    logic [31:0]       last_hits;

    pla_seq_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) bus ();

    pla_seq_engine #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .N_TERMS (N_TERMS),
        .LANES   (LANES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int t = 0; t < N_TERMS; t++) begin
            m_cube[t] = '0;
            m_row[t]  = '0;
        end
    endtask

    task automatic modelWrite(input int addr, input logic [2*N_IN-1:0] c, input logic [N_OUT-1:0] r);
        if (addr < N_TERMS) begin
            m_cube[addr] = c;
            m_row[addr]  = r;
        end
    endtask

    // Every term is tested in full against the vector; matches OR their rows.
    task automatic modelEval(input logic [N_IN-1:0] x, output logic [N_OUT-1:0] z, output int hits);
        z    = '0;
        hits = 0;
        for (int t = 0; t < N_TERMS; t++) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                logic [1:0] c;
                c = m_cube[t][2*i +: 2];
                if (c == CUBE_NULL) ok = 1'b0;
                else if (c == CUBE_ONE && !x[i]) ok = 1'b0;
                else if (c == CUBE_ZERO && x[i]) ok = 1'b0;
            end
            if (ok) begin
                z = z | m_row[t];
                hits++;
            end
        end
        if (hits > N_TERMS) hits = N_TERMS;
    endtask

    function automatic logic [2*N_IN-1:0] mkCube(input logic [N_IN-1:0] ones, input logic [N_IN-1:0] zeros);
        logic [2*N_IN-1:0] c;
        for (int i = 0; i < N_IN; i++) begin
            if (ones[i])       c[2*i +: 2] = CUBE_ONE;
            else if (zeros[i]) c[2*i +: 2] = CUBE_ZERO;
            else               c[2*i +: 2] = CUBE_DC;
        end
        return c;
    endfunction

    function automatic logic [2*N_IN-1:0] randCube();
        logic [2*N_IN-1:0] c;
        int r;
        for (int i = 0; i < N_IN; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      c[2*i +: 2] = CUBE_NULL;
            else if (r <= 2) c[2*i +: 2] = CUBE_ONE;
            else if (r <= 4) c[2*i +: 2] = CUBE_ZERO;
            else             c[2*i +: 2] = CUBE_DC;
        end
        return c;
    endfunction

    task automatic progWrite(input int addr, input logic [2*N_IN-1:0] c, input logic [N_OUT-1:0] r);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(addr);
        bus.prog_and  = c;
        bus.prog_or   = r;
        tick();
        bus.prog_we   = 1'b0;
        modelWrite(addr, c, r);
    endtask

    // Offers one vector, optionally with a colliding write or a write during EVAL,
    // checks latency and result, then holds the result for 'hold' cycles and drains it.
    task automatic applyStimulus(input logic [N_IN-1:0] x, input int hold, input bit collide,
                                 input int caddr, input logic [2*N_IN-1:0] ccube,
                                 input logic [N_OUT-1:0] crow, input bit eval_write);
        logic [N_OUT-1:0] ez;
        int eh;
        int cnt;
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        if (collide) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = AW'(caddr);
            bus.prog_and  = ccube;
            bus.prog_or   = crow;
            modelWrite(caddr, ccube, crow);
        end
        modelEval(x, ez, eh);
        tick();
        bus.in_valid = 1'b0;
        bus.prog_we  = 1'b0;
        bus.in_x     = N_IN'($urandom);
        checkOutput("eval_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("eval_out_z", 32'(bus.out_z), 32'd0);
        checkOutput("eval_out_hits", 32'(bus.out_hits), 32'd0);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 64) begin
            if (eval_write && cnt == 1) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = AW'($urandom_range(0, N_TERMS - 1));
                bus.prog_and  = mkCube('0, '0);
                bus.prog_or   = '1;
            end
            tick();
            bus.prog_we = 1'b0;
            cnt++;
        end
        checkOutput("latency", 32'(cnt), 32'(G));
        checkOutput("out_z", 32'(bus.out_z), 32'(ez));
        checkOutput("out_hits", 32'(bus.out_hits), 32'(eh));
        last_z    = bus.out_z;
        last_hits = 32'(bus.out_hits);
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_z", 32'(bus.out_z), 32'(ez));
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [N_IN-1:0]  x;
        logic [N_OUT-1:0] saved_z;
        logic [31:0]      saved_hits;
        bit seen;

        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_and  = '0;
        bus.prog_or   = '0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        modelClear();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_z", 32'(bus.out_z), 32'd0);
        checkOutput("rst_out_hits", 32'(bus.out_hits), 32'd0);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(N_IN'($urandom), 0, 1'b0, 0, '0, '0, 1'b0);
            checkOutput("empty_plane_z", 32'(last_z), 32'd0);
        end

        progWrite(0, mkCube(10'b1110001000, 10'b0001110111), 12'h040);
        applyStimulus(10'b1110001000, 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("single_z", 32'(last_z), 32'h040);
        checkOutput("single_hits", last_hits, 32'd1);
        applyStimulus(10'b1110001001, 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("single_miss_z", 32'(last_z), 32'h000);

        progWrite(3, mkCube('0, '0), 12'h001);
        progWrite(31, mkCube('0, '0), 12'h800);
        applyStimulus(10'b1110001001, 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("multi_z", 32'(last_z), 32'h801);
        checkOutput("multi_hits", last_hits, 32'd2);
        applyStimulus(N_IN'($urandom), 0, 1'b0, 0, '0, '0, 1'b0);

        begin
            logic [2*N_IN-1:0] c;
            int p;
            c = mkCube('0, '0);
            p = $urandom_range(0, N_IN - 1);
            c[2*p +: 2] = CUBE_NULL;
            progWrite(5, c, 12'h010);
        end
        applyStimulus(10'b1110001001, 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("null_term_z", 32'(last_z), 32'h801);

        x = N_IN'($urandom);
        applyStimulus(x, 0, 1'b0, 0, '0, '0, 1'b1);
        saved_z    = last_z;
        saved_hits = last_hits;
        applyStimulus(x, 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("requery_z", 32'(last_z), 32'(saved_z));
        checkOutput("requery_hits", last_hits, saved_hits);

        applyStimulus(N_IN'($urandom), 5, 1'b0, 0, '0, '0, 1'b0);

        applyStimulus(10'b1110001001, 0, 1'b1, 0, mkCube('0, '0), 12'h002, 1'b0);
        checkOutput("collide_z", 32'(last_z), 32'h803);
        checkOutput("collide_hits", last_hits, 32'd3);

        for (int k = 0; k < 16; k++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                progWrite($urandom_range(0, N_TERMS - 1), randCube(), N_OUT'($urandom));
            end
            applyStimulus(N_IN'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          $urandom_range(0, N_TERMS - 1), randCube(), N_OUT'($urandom), 1'b0);
        end

        bus.in_x     = N_IN'($urandom);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelClear();
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < G + 4; c++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checkOutput("midrst_no_valid", 32'(seen), 32'd0);
        applyStimulus(N_IN'($urandom), 0, 1'b0, 0, '0, '0, 1'b0);
        checkOutput("midrst_query_z", 32'(last_z), 32'd0);
        checkOutput("midrst_query_hits", last_hits, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
